scan_chain_engine: RTL and testbench

//  Multi-word scan-chain load/unload engine between the Wishbone register decoder and the

---
 rtl/scan_chain_engine.sv | 94 +++++++++
 tb/tb_scan_chain_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_engine.sv
// Multi-word scan-chain load/unload engine: shifts a staged NUM_WORDS x 32-bit buffer into the
// processor scan chain while capturing the chain's previous contents back into the same buffer.
module scan_chain_engine #(
    parameter int NUM_WORDS = 8,
    parameter int AW        = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic [31:0]   cfg_rdata,
    input  logic          start,
    input  logic          proc_en_i,
    output logic          busy,
    output logic          done,
    output logic          start_err,
    output logic          scan_enable,
    output logic          scan_in,
    input  logic          scan_out
);

    localparam int N  = 32 * NUM_WORDS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    shift_buf;

    assign busy    = (state_q == SHIFT);
    assign scan_in = shift_buf[N-1];

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        cfg_rdata = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (cfg_addr == AW'(k)) begin
                cfg_rdata = shift_buf[32*k +: 32];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the buffer is reset explicitly because software can read it straight after reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_buf   <= '0;
            done        <= 1'b0;
            start_err   <= 1'b0;
            scan_enable <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A write accepted alongside start is staged before the first shift edge.
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (cfg_we && cfg_addr == AW'(k)) begin
                            shift_buf[32*k +: 32] <= cfg_wdata;
                        end
                    end
                    if (start) begin
                        if (proc_en_i) begin
                            start_err <= 1'b1;
                        end else begin
                            state_q     <= SHIFT;
                            cnt_q       <= CW'(N - 1);
                            scan_enable <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shift_buf <= {shift_buf[N-2:0], scan_out};
                    if (cnt_q == '0) begin
                        scan_enable <= 1'b0;
                        state_q     <= IDLE;
                        done        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_engine.sv
// Bench for scan_chain_engine: two instances (2 and 8 words) against loopback chain models and a
// transaction-level buffer/chain reference model, plus literal checks of the key scenarios.
module tb_scan_chain_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  cfg_we = '0;
    logic [1:0]  start_r = '0;
    logic [1:0]  proc_en = '0;
    logic [0:0]  cfg_addr2 = '0;
    logic [2:0]  cfg_addr8 = '0;
    logic [31:0] cfg_wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  busy_w, done_w, err_w, se_w, si_w, so_w;

    logic [63:0]  chain2 = '0;
    logic [255:0] chain8 = '0;
    assign so_w[0] = chain2[63];
    assign so_w[1] = chain8[255];

    // Processor chain stand-ins: shift on each edge where scan_enable is high.
    always @(posedge clk) begin
        if (se_w[0]) chain2 <= {chain2[62:0], si_w[0]};
        if (se_w[1]) chain8 <= {chain8[254:0], si_w[1]};
    end

    scan_chain_engine #(.NUM_WORDS(2), .AW(1)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr2),
        .cfg_wdata(cfg_wdata[0]), .cfg_rdata(rdata[0]), .start(start_r[0]),
        .proc_en_i(proc_en[0]), .busy(busy_w[0]), .done(done_w[0]), .start_err(err_w[0]),
        .scan_enable(se_w[0]), .scan_in(si_w[0]), .scan_out(so_w[0])
    );

    scan_chain_engine u_dut8 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr8),
        .cfg_wdata(cfg_wdata[1]), .cfg_rdata(rdata[1]), .start(start_r[1]),
        .proc_en_i(proc_en[1]), .busy(busy_w[1]), .done(done_w[1]), .start_err(err_w[1]),
        .scan_enable(se_w[1]), .scan_in(si_w[1]), .scan_out(so_w[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int nw(input int d);
        return (d != 0) ? 8 : 2;
    endfunction

    function automatic int cur_addr(input int d);
        return (d != 0) ? int'(cfg_addr8) : int'(cfg_addr2);
    endfunction

    function automatic logic [255:0] chain_v(input int d);
        return (d != 0) ? chain8 : {192'b0, chain2};
    endfunction

    // Reference model: a scan is a transaction lasting N cycles that swaps buffer and chain.
    int           m_rem [2];
    logic [31:0]  m_words [2][8];
    logic [255:0] m_staged [2];
    logic [255:0] m_old [2];
    bit           m_done [2];
    bit           m_err [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_rem[d] = 0; m_done[d] = 0; m_err[d] = 0;
                for (int k = 0; k < 8; k++) m_words[d][k] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_done[d] = 0;
                m_err[d]  = 0;
                if (m_rem[d] > 0) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        m_done[d] = 1;
                        for (int k = 0; k < nw(d); k++) m_words[d][k] = m_old[d][32*k +: 32];
                    end
                end else begin
                    if (cfg_we[d]) m_words[d][cur_addr(d)] = cfg_wdata[d];
                    if (start_r[d]) begin
                        if (proc_en[d]) begin
                            m_err[d] = 1;
                        end else begin
                            m_rem[d]    = 32 * nw(d);
                            m_staged[d] = '0;
                            for (int k = 0; k < nw(d); k++) m_staged[d][32*k +: 32] = m_words[d][k];
                            m_old[d] = chain_v(d);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check("scan_enable", se_w[d], m_rem[d] > 0);
                check("busy", busy_w[d], m_rem[d] > 0);
                check("done", done_w[d], m_done[d]);
                check("start_err", err_w[d], m_err[d]);
                if (m_rem[d] == 0) begin
                    check("cfg_rdata", rdata[d], m_words[d][cur_addr(d)]);
                    check("scan_in", si_w[d], m_words[d][nw(d)-1][31]);
                end
                if (m_done[d]) check("chain_load", chain_v(d), m_staged[d]);
            end
        end
    end

    int en_tot [2] = '{0, 0};
    int done_tot [2] = '{0, 0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (se_w[d]) en_tot[d]++;
            if (done_w[d]) done_tot[d]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int d, input int a);
        if (d != 0) cfg_addr8 = 3'(a);
        else cfg_addr2 = 1'(a);
    endtask

    task automatic write_word(input int d, input int a, input logic [31:0] data);
        set_addr(d, a);
        cfg_we[d] = 1'b1;
        cfg_wdata[d] = data;
        tick();
        cfg_we[d] = 1'b0;
    endtask

    task automatic do_start(input int d, input logic pen);
        start_r[d] = 1'b1;
        proc_en[d] = pen;
        tick();
        start_r[d] = 1'b0;
        proc_en[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        bit seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_w[d]) seen = 1;
        end
        check("scan_done_seen", seen, 1'b1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic readback(input string name, input int d, input int a, input logic [31:0] exp);
        set_addr(d, a);
        #1;
        check(name, rdata[d], exp);
    endtask

    int base_en, base_done;
    logic [255:0] pattern;
    logic pen_r;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_wdata[0] = '0;
        cfg_wdata[1] = '0;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset_scan_enable", se_w[d], 1'b0);
            check("reset_busy", busy_w[d], 1'b0);
            check("reset_done", done_w[d], 1'b0);
            check("reset_start_err", err_w[d], 1'b0);
            check("reset_scan_in", si_w[d], 1'b0);
            check("reset_rdata", rdata[d], 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // 1: load two words into an all-zero chain.
        write_word(0, 0, 32'hDEADBEEF);
        write_word(0, 1, 32'h01234567);
        base_en = en_tot[0]; base_done = done_tot[0];
        do_start(0, 1'b0);
        wait_done(0);
        check("t1_enable_cycles", en_tot[0] - base_en, 64);
        check("t1_done_count", done_tot[0] - base_done, 1);
        check("t1_chain", chain2, 64'h01234567_DEADBEEF);
        readback("t1_w0", 0, 0, 32'h0);
        readback("t1_w1", 0, 1, 32'h0);

        // 2: scan zeros back in, recovering the previous chain contents.
        tick();
        write_word(0, 0, 32'h0);
        write_word(0, 1, 32'h0);
        do_start(0, 1'b0);
        wait_done(0);
        check("t2_chain", chain2, 64'h0);
        readback("t2_w1", 0, 1, 32'h01234567);
        readback("t2_w0", 0, 0, 32'hDEADBEEF);

        // 3: start refused while the processor runs.
        tick();
        do_start(0, 1'b1);
        @(negedge clk);
        #1;
        check("t3_start_err", err_w[0], 1'b1);
        check("t3_busy", busy_w[0], 1'b0);
        check("t3_scan_enable", se_w[0], 1'b0);
        @(negedge clk);
        #1;
        check("t3_start_err_cleared", err_w[0], 1'b0);
        readback("t3_w0", 0, 0, 32'hDEADBEEF);

        // 4: repeated start and a write mid-scan are both ignored.
        tick();
        base_en = en_tot[0]; base_done = done_tot[0];
        do_start(0, 1'b0);
        repeat (10) tick();
        start_r[0] = 1'b1;
        cfg_we[0] = 1'b1;
        cfg_addr2 = 1'b0;
        cfg_wdata[0] = 32'hFFFFFFFF;
        tick();
        start_r[0] = 1'b0;
        cfg_we[0] = 1'b0;
        wait_done(0);
        check("t4_enable_cycles", en_tot[0] - base_en, 64);
        check("t4_done_count", done_tot[0] - base_done, 1);
        check("t4_chain", chain2, 64'h01234567_DEADBEEF);
        readback("t4_w0", 0, 0, 32'h0);

        // 5: reset in the middle of a scan.
        tick();
        write_word(0, 0, 32'hA5A5A5A5);
        do_start(0, 1'b0);
        repeat (20) tick();
        base_done = done_tot[0];
        rst_n = 1'b0;
        #1;
        check("t5_scan_enable", se_w[0], 1'b0);
        check("t5_busy", busy_w[0], 1'b0);
        readback("t5_w0", 0, 0, 32'h0);
        readback("t5_w1", 0, 1, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (80) tick();
        check("t5_no_done", done_tot[0] - base_done, 0);
        check("t5_idle_after", busy_w[0], 1'b0);

        // 6: full 256-bit chain with random patterns.
        for (int k = 0; k < 8; k++) begin
            pattern[32*k +: 32] = $urandom;
            write_word(1, k, pattern[32*k +: 32]);
        end
        base_en = en_tot[1];
        do_start(1, 1'b0);
        wait_done(1);
        check("t6_enable_cycles", en_tot[1] - base_en, 256);
        check("t6_chain", chain8, pattern);
        for (int it = 0; it < 4; it++) begin
            tick();
            for (int k = 0; k < 8; k++) write_word(1, k, $urandom);
            pen_r = ($urandom_range(0, 3) == 0);
            base_en = en_tot[1];
            do_start(1, pen_r);
            if (pen_r) begin
                repeat (4) tick();
                check("t6_refused_enable", en_tot[1] - base_en, 0);
            end else begin
                wait_done(1);
                check("t6_rand_enable_cycles", en_tot[1] - base_en, 256);
            end
            for (int k = 0; k < 8; k++) readback("t6_readback", 1, k, m_words[1][k]);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
